// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter that lets NUM_REQ simple requesters share one AHB-to-APB bridge,
// issuing one non-pipelined AHB-lite transfer per grant and returning data/error to the owner.
module apb_bridge_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [NUM_REQ-1:0]     RWRITE,
    input  logic [32*NUM_REQ-1:0]  RADDR,
    input  logic [32*NUM_REQ-1:0]  RWDATA,
    output logic [NUM_REQ-1:0]     ACK,
    output logic [31:0]            RRDATA,
    output logic                   RERR,
    output logic [IDX_W-1:0]       GNT_IDX,
    output logic                   BUSY,
    output logic                   HSEL,
    output logic [31:0]            HADDR,
    output logic                   HWRITE,
    output logic [1:0]             HTRANS,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic [31:0]            HWDATA,
    input  logic                   HREADY,
    input  logic                   HRESP,
    input  logic [31:0]            HRDATA
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] winner;
    logic             grant;
    logic [31:0]      raddr_a  [NUM_REQ];
    logic [31:0]      rwdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign raddr_a[g]  = RADDR[32*g +: 32];
        assign rwdata_a[g] = RWDATA[32*g +: 32];
    end

    // Scan downward so the last hit is the nearest set bit above the previous owner.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand   = GNT_IDX;
        winner = GNT_IDX;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(GNT_IDX) + k) % NUM_REQ);
            if (REQ[cand]) begin
                winner = cand;
            end
        end
    end

    assign grant = (state == IDLE) && (|REQ) && HREADY;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant)  next_state = ADDR;
            ADDR:                next_state = DATA;
            DATA:    if (HREADY) next_state = DONE;
            DONE:                next_state = IDLE;
            default:             next_state = IDLE;
        endcase
    end

    // Bus controls decode only the state register, so no input reaches an output combinationally.
    always_comb begin
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        BUSY   = 1'b0;
        ACK    = '0;
        case (state)
            ADDR: begin
                HSEL   = 1'b1;
                HTRANS = 2'b10;
                BUSY   = 1'b1;
            end
            DATA: begin
                BUSY   = 1'b1;
            end
            DONE: begin
                BUSY   = 1'b1;
                ACK    = NUM_REQ'(1) << GNT_IDX;
            end
            default: begin
                BUSY   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            GNT_IDX <= IDX_W'(NUM_REQ - 1);
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
            RRDATA  <= '0;
            RERR    <= 1'b0;
        end else begin
            if (grant) begin
                GNT_IDX <= winner;
                HADDR   <= raddr_a[winner];
                HWRITE  <= RWRITE[winner];
                HWDATA  <= rwdata_a[winner];
            end
            // Error responses hold HREADY low on their first cycle, so only the ready cycle is sampled.
            if (state == DATA && HREADY) begin
                RRDATA  <= HRDATA;
                RERR    <= HRESP;
            end
        end
    end

    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;

endmodule
